// File: rtl/out_quant_packer.sv
// out_quant_packer: requantizes signed accumulator samples and packs them into wide words for the capture memory
module out_quant_packer #(
    parameter int WIDTH      = 256,
    parameter int DAT_W      = 8,
    parameter int ACC_W      = 32,
    parameter int log2_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic [log2_DEPTH-1:0] cfg_word_num,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [ACC_W-1:0]      in_acc,
    input  logic                  in_last,
    output logic                  dat_vld,
    output logic [WIDTH-1:0]      dat,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);
    localparam int PACK = WIDTH / DAT_W;
    localparam int LW = PACK > 1 ? $clog2(PACK) : 1;
    localparam logic signed [ACC_W:0] QMAX = {{(ACC_W-DAT_W+2){1'b0}}, {(DAT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] QMIN = {{(ACC_W-DAT_W+2){1'b1}}, {(DAT_W-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_nxt;
    logic [4:0] shift;
    logic relu;
    logic [log2_DEPTH-1:0] word_num, in_word;
    logic [LW-1:0] in_lane, lane;
    logic q_vld, q_last;
    logic [DAT_W-1:0] q_dat, sat;
    logic [WIDTH-1:0] buf_q, buf_nxt;
    logic [ACC_W:0] rnd;
    logic signed [ACC_W:0] s, q, r;
    logic acc_ok, lane_full, frame_end, emit;
    assign acc_ok = in_vld & in_rdy;
    assign lane_full = in_lane == LW'(PACK - 1);
    // the frame ends on an explicit last or when the programmed final word fills up
    assign frame_end = in_last | (lane_full & (in_word == word_num));
    assign emit = q_vld & (q_last | (lane == LW'(PACK - 1)));
    assign in_rdy = state == RUN;
    assign busy = state != IDLE;
    assign frame_done = state == FIN;
    always_comb begin
        rnd = shift == 5'd0 ? '0 : (ACC_W+1)'(1) << (shift - 5'd1);
        s = $signed({in_acc[ACC_W-1], in_acc}) + $signed(rnd);
        q = s >>> shift;
        r = (relu && q < 0) ? '0 : q;
        sat = r > QMAX ? {1'b0, {(DAT_W-1){1'b1}}} : r < QMIN ? {1'b1, {(DAT_W-1){1'b0}}} : r[DAT_W-1:0];
        buf_nxt = buf_q;
        buf_nxt[lane*DAT_W +: DAT_W] = q_dat;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (acc_ok && frame_end) ? DRAIN : RUN;
            // the last accepted sample is in the quantize stage for exactly one DRAIN cycle
            DRAIN:   state_nxt = (dat_vld && !q_vld) ? FIN : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            relu     <= 1'b0;
            word_num <= '0;
            in_word  <= '0;
            in_lane  <= '0;
            lane     <= '0;
            q_vld    <= 1'b0;
            q_last   <= 1'b0;
            q_dat    <= '0;
            buf_q    <= '0;
            dat      <= '0;
            dat_vld  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_nxt;
            q_vld   <= acc_ok;
            q_last  <= in_last;
            q_dat   <= sat;
            dat_vld <= emit;
            if (emit) begin
                dat   <= buf_nxt;
                buf_q <= '0;
                lane  <= '0;
            end else if (q_vld) begin
                buf_q <= buf_nxt;
                lane  <= lane + LW'(1);
            end
            if (start && state == IDLE) begin
                shift    <= cfg_shift;
                relu     <= cfg_relu;
                word_num <= cfg_word_num;
                in_word  <= '0;
                in_lane  <= '0;
                err      <= 1'b0;
            end else if (acc_ok) begin
                in_lane <= (lane_full || in_last) ? '0 : in_lane + LW'(1);
                in_word <= (lane_full || in_last) ? in_word + log2_DEPTH'(1) : in_word;
                if ((in_last && in_word != word_num) || (lane_full && in_word == word_num && !in_last))
                    err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_out_quant_packer.sv
// tb_out_quant_packer: directed vectors with hand-computed packed words for out_quant_packer
module tb_out_quant_packer;
    logic         clk = 0;
    logic         rst = 1;
    logic         start = 0;
    logic [4:0]   cfg_shift = 0;
    logic         cfg_relu = 0;
    logic [2:0]   cfg_word_num = 0;
    logic         in_vld = 0;
    logic         in_rdy;
    logic [31:0]  in_acc = 0;
    logic         in_last = 0;
    logic         dat_vld;
    logic [255:0] dat;
    logic         busy;
    logic         frame_done;
    logic         err;
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int fd_cyc = 0;
    int t31 = 0;
    logic [255:0] words[$];
    int vcyc[$];

    out_quant_packer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .cfg_word_num(cfg_word_num), .in_vld(in_vld), .in_rdy(in_rdy), .in_acc(in_acc),
        .in_last(in_last), .dat_vld(dat_vld), .dat(dat), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (dat_vld) begin
            words.push_back(dat);
            vcyc.push_back(cyc);
        end
        if (frame_done) fd_cyc = cyc;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int sh, input bit rl, input int wn);
        words.delete();
        vcyc.delete();
        start = 1;
        cfg_shift = 5'(sh);
        cfg_relu = rl;
        cfg_word_num = 3'(wn);
        tick();
        start = 0;
    endtask

    task automatic send(input logic [31:0] a, input logic l);
        int t = 0;
        in_vld = 1;
        in_acc = a;
        in_last = l;
        while (!in_rdy && t < 50) begin
            tick();
            t++;
        end
        if (!in_rdy) check("send_timeout", 0, 1);
        acc_cyc = cyc;
        tick();
        in_vld = 0;
        in_last = 0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!frame_done && t < 2000) begin
            tick();
            t++;
        end
        check(tag, frame_done, 1);
        tick();
    endtask

    function automatic logic [255:0] full_word(input int w);
        logic [255:0] v = '0;
        for (int k = 0; k < 32; k++) v[k*8 +: 8] = 8'((32*w + k) > 127 ? 127 : 32*w + k);
        return v;
    endfunction

    initial begin
        repeat (3) tick();
        check("rst0_in_rdy", in_rdy, 0);
        check("rst0_busy", busy, 0);
        check("rst0_dat", dat, 0);
        rst = 0;
        tick();

        start_frame(4, 0, 0);
        check("busy_after_start", busy, 1);
        send(24, 0); send(-24, 0); send(5000, 0); send(-5000, 0); send(7, 1);
        wait_done("rq_done");
        check("rq_cnt", 256'(words.size()), 1);
        check("rq_word", words.size() > 0 ? words[0] : '0, 256'h807FFF02);
        check("rq_err", err, 0);

        start_frame(4, 1, 0);
        send(24, 0); send(-24, 0); send(5000, 0); send(-5000, 0); send(7, 1);
        wait_done("relu_done");
        check("relu_word", words.size() > 0 ? words[0] : '0, 256'h7F0002);

        start_frame(2, 0, 7);
        for (int i = 0; i < 256; i++) begin
            send(32'(i << 2), i == 255);
            if (i == 31) t31 = acc_cyc;
        end
        wait_done("full_done");
        repeat (5) tick();
        check("full_cnt", 256'(words.size()), 8);
        for (int w = 0; w < 8; w++) check($sformatf("full_w%0d", w), w < words.size() ? words[w] : '0, full_word(w));
        check("full_lat", 256'(vcyc.size() > 0 ? vcyc[0] : 0), 256'(t31 + 2));
        check("full_fd_lat", 256'(fd_cyc), 256'(vcyc.size() > 7 ? vcyc[7] + 1 : -1));
        check("full_err", err, 0);
        check("full_busy", busy, 0);

        start_frame(0, 0, 0);
        for (int i = 0; i < 5; i++) send(1, i == 4);
        wait_done("part_done");
        check("part_word", words.size() > 0 ? words[0] : '0, 256'h0101010101);
        check("part_err", err, 0);

        start_frame(0, 0, 1);
        for (int i = 0; i < 10; i++) send(1, i == 9);
        wait_done("early_done");
        check("early_cnt", 256'(words.size()), 1);
        check("early_word", words.size() > 0 ? words[0] : '0, 256'({10{8'h01}}));
        check("early_err", err, 1);

        start_frame(1, 0, 0);
        for (int i = 0; i < 32; i++) send(2, 0);
        check("nolast_rdy", in_rdy, 0);
        wait_done("nolast_done");
        check("nolast_cnt", 256'(words.size()), 1);
        check("nolast_word", words.size() > 0 ? words[0] : '0, {32{8'h01}});
        check("nolast_err", err, 1);

        start_frame(2, 0, 7);
        check("restart_err", err, 0);
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            if (i == 100) begin
                start = 1;
                cfg_shift = 0;
            end
            send(32'(i << 2), i == 255);
            start = 0;
            cfg_shift = 2;
        end
        wait_done("thr_done");
        check("thr_cnt", 256'(words.size()), 8);
        for (int w = 0; w < 8; w++) check($sformatf("thr_w%0d", w), w < words.size() ? words[w] : '0, full_word(w));
        check("thr_err", err, 0);

        start_frame(2, 0, 7);
        for (int i = 0; i < 40; i++) send(32'(i << 2), 0);
        check("mid_words", 256'(words.size()), 1);
        rst = 1;
        repeat (3) tick();
        check("rst_in_rdy", in_rdy, 0);
        check("rst_dat_vld", dat_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_dat", dat, 0);
        rst = 0;
        repeat (10) tick();
        check("rst_no_words", 256'(words.size()), 1);
        check("rst_idle_rdy", in_rdy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
